// File: rtl/stream_demux_buffered_if.sv
`default_nettype none
// ============================================================================
//  Module   : stream_demux_buffered_if
//  Brief    : Bus bundle for the buffered 1-to-N stream demultiplexer: the
//             upstream valid/ready/select stream, the N downstream streams and
//             the debug counters.
//  Revision : 1.0  initial release
// ============================================================================
interface stream_demux_buffered_if #(
    parameter int N_OUT = 4,
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    localparam int SW = $clog2(N_OUT);

    logic                   up_valid;
    logic [SW-1:0]          up_sel;
    logic [W-1:0]           up_data;
    logic                   up_ready;
    logic [N_OUT-1:0]       dn_valid;
    logic [N_OUT*W-1:0]     dn_data;
    logic [N_OUT-1:0]       dn_ready;
    logic [N_OUT*CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0]       drop_cnt;

    // Demux side: consumes the upstream stream, produces the downstream ones.
    modport slave (
        input  up_valid, up_sel, up_data, dn_ready,
        output up_ready, dn_valid, dn_data, beat_cnt, drop_cnt
    );

    // Environment side: produces the upstream stream, consumes the downstream.
    modport master (
        output up_valid, up_sel, up_data, dn_ready,
        input  up_ready, dn_valid, dn_data, beat_cnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/stream_demux_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : stream_demux_buffered
//  Brief    : Registered 1-to-N stream demultiplexer. Each output owns a
//             2-entry FIFO so a stalled output never blocks other outputs.
//             Saturating per-output beat counters and an out-of-range drop
//             counter are provided for debug.
//  Revision : 1.0  initial release
// ============================================================================
module stream_demux_buffered #(
    parameter int N_OUT = 4,
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    stream_demux_buffered_if.slave bus
);
    localparam int              SW        = $clog2(N_OUT);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // FIFO storage, 1-bit pointers (depth 2 wraps naturally) and occupancy.
    logic [W-1:0]     r_mem  [N_OUT][2];
    logic [N_OUT-1:0] r_wp;
    logic [N_OUT-1:0] r_rp;
    logic [1:0]       r_cnt  [N_OUT];
    logic [CNT_W-1:0] r_beat [N_OUT];
    logic [CNT_W-1:0] r_drop;

    logic                   w_in_range;
    logic                   w_sel_full;
    logic                   w_up_ready;
    logic                   w_accept;
    logic                   w_drop;
    logic [N_OUT-1:0]       w_push;
    logic [N_OUT-1:0]       w_pop;
    logic [N_OUT-1:0]       w_dn_valid;
    logic [N_OUT*W-1:0]     w_dn_data;
    logic [N_OUT*CNT_W-1:0] w_beat;

    // Accept/steer decision. up_ready depends only on registered occupancy of
    // the selected FIFO, never on dn_ready, so there is no ready-to-ready path.
    always_comb begin
        w_in_range = (32'(bus.up_sel) < 32'(N_OUT));
        w_sel_full = 1'b0;
        w_push     = '0;
        w_pop      = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (bus.up_sel == SW'(i)) begin
                w_sel_full = (r_cnt[i] == 2'd2);
            end
        end
        w_up_ready = rst_n & (~w_in_range | ~w_sel_full);
        w_accept   = bus.up_valid & w_up_ready;
        w_drop     = w_accept & ~w_in_range;
        for (int i = 0; i < N_OUT; i++) begin
            w_push[i] = w_accept & w_in_range & (bus.up_sel == SW'(i));
            w_pop[i]  = (r_cnt[i] != 2'd0) & bus.dn_ready[i];
        end
    end

    // FIFO storage, pointers and occupancy; a pop and push in the same cycle
    // leave the count unchanged while the head moves on to the next beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_mem[i][0] <= '0;
                r_mem[i][1] <= '0;
                r_cnt[i]    <= 2'd0;
            end
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_push[i]) begin
                    r_mem[i][r_wp[i]] <= bus.up_data;
                    r_wp[i]           <= ~r_wp[i];
                end
                if (w_pop[i]) begin
                    r_rp[i] <= ~r_rp[i];
                end
                r_cnt[i] <= r_cnt[i] + {1'b0, w_push[i]} - {1'b0, w_pop[i]};
            end
        end
    end

    // Saturating debug counters: delivered beats per output and dropped beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_beat[i] <= '0;
            end
            r_drop <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_pop[i] && (r_beat[i] != c_cnt_max)) begin
                    r_beat[i] <= r_beat[i] + CNT_W'(1);
                end
            end
            if (w_drop && (r_drop != c_cnt_max)) begin
                r_drop <= r_drop + CNT_W'(1);
            end
        end
    end

    // Flatten per-output state onto the packed output buses; the head entry is
    // presented directly so data stays put while the output waits.
    always_comb begin
        w_dn_valid = '0;
        w_dn_data  = '0;
        w_beat     = '0;
        for (int i = 0; i < N_OUT; i++) begin
            w_dn_valid[i]             = (r_cnt[i] != 2'd0);
            w_dn_data[i*W +: W]       = r_mem[i][r_rp[i]];
            w_beat[i*CNT_W +: CNT_W]  = r_beat[i];
        end
    end

    assign bus.up_ready = w_up_ready;
    assign bus.dn_valid = w_dn_valid;
    assign bus.dn_data  = w_dn_data;
    assign bus.beat_cnt = w_beat;
    assign bus.drop_cnt = r_drop;

endmodule
`default_nettype wire
